// File: rtl/crtc_pkg.sv
// CRTC register file shared definitions: register indices,
// field widths and the power-on register table.
package crtc_pkg;

  localparam int NREGS = 16;

  localparam logic [4:0] R0_H_TOTAL     = 5'd0;
  localparam logic [4:0] R1_H_DISPLAYED = 5'd1;
  localparam logic [4:0] R2_H_SYNC_POS  = 5'd2;
  localparam logic [4:0] R3_SYNC_WIDTH  = 5'd3;
  localparam logic [4:0] R4_V_TOTAL     = 5'd4;
  localparam logic [4:0] R5_V_ADJUST    = 5'd5;
  localparam logic [4:0] R6_V_DISPLAYED = 5'd6;
  localparam logic [4:0] R7_V_SYNC_POS  = 5'd7;
  localparam logic [4:0] R9_SCAN_LINE   = 5'd9;
  localparam logic [4:0] R12_START_HI   = 5'd12;
  localparam logic [4:0] R13_START_LO   = 5'd13;
  localparam logic [4:0] R14_CURSOR_HI  = 5'd14;
  localparam logic [4:0] R15_CURSOR_LO  = 5'd15;

  localparam int H_W    = 8;
  localparam int SW_W   = 4;
  localparam int V_W    = 7;
  localparam int ADJ_W  = 5;
  localparam int SCAN_W = 5;
  localparam int ADDR_W = 14;

  function automatic logic [7:0] reset_val(input logic [3:0] idx);
    logic [7:0] v;
    v = 8'h00;
    case (idx)
      4'd0:    v = 8'd63;
      4'd1:    v = 8'd40;
      4'd2:    v = 8'd48;
      4'd3:    v = 8'h15;
      4'd4:    v = 8'd32;
      4'd6:    v = 8'd25;
      4'd7:    v = 8'd28;
      4'd9:    v = 8'd7;
      4'd12:   v = 8'h10;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic reg_exists(input logic [4:0] idx);
    return (idx <= 5'd15) && (idx != 5'd8) &&
           (idx != 5'd10) && (idx != 5'd11);
  endfunction

endpackage

// File: rtl/crtc_edge_det.sv
// Rising-edge detector against a registered copy of the input.
module crtc_edge_det (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q, sig_d;

  always_comb sig_d = sig_i;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) sig_q <= 1'b0;
    else           sig_q <= sig_d;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/crtc_regs.sv
// CRTC CPU-visible register file with staging registers that
// commit to the timing outputs at each vertical sync.
module crtc_regs
  import crtc_pkg::*;
#(
  parameter bit IMMEDIATE = 1'b0
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              cs_i,
  input  logic              rs_i,
  input  logic              we_i,
  input  logic              rd_i,
  input  logic [7:0]        data_i,
  output logic [7:0]        data_o,
  input  logic              v_sync_i,
  output logic [H_W-1:0]    h_total_o,
  output logic [H_W-1:0]    h_displayed_o,
  output logic [H_W-1:0]    h_sync_pos_o,
  output logic [SW_W-1:0]   h_sync_width_o,
  output logic [SW_W-1:0]   v_sync_width_o,
  output logic [V_W-1:0]    v_total_o,
  output logic [ADJ_W-1:0]  v_adjust_o,
  output logic [V_W-1:0]    v_displayed_o,
  output logic [V_W-1:0]    v_sync_pos_o,
  output logic [SCAN_W-1:0] scan_line_o,
  output logic [ADDR_W-1:0] display_start_o,
  output logic [ADDR_W-1:0] cursor_o,
  output logic              pending_o
);

  logic [4:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic [7:0] stg_q [NREGS];
  logic [7:0] stg_d [NREGS];
  logic [7:0] com [NREGS];
  logic       rise;
  logic       dwr;
  logic       changed;

  crtc_edge_det u_vs_edge (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .sig_i    (v_sync_i),
    .rise_o   (rise)
  );

  always_comb begin
    idx_d   = idx_q;
    stg_d   = stg_q;
    data_d  = data_q;
    dwr     = 1'b0;
    changed = 1'b0;
    if (cs_i && we_i && !rs_i) idx_d = data_i[4:0];
    if (cs_i && we_i && rs_i && reg_exists(idx_q)) begin
      dwr = 1'b1;
      changed = (stg_q[idx_q[3:0]] != data_i);
      stg_d[idx_q[3:0]] = data_i;
    end
    // a simultaneous write wins; the read is dropped
    if (cs_i && rd_i && !we_i) begin
      if (!rs_i)                        data_d = 8'h00;
      else if (idx_q == R14_CURSOR_HI) data_d = com[14];
      else if (idx_q == R15_CURSOR_LO) data_d = com[15];
      else                              data_d = 8'h00;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      idx_q  <= 5'd0;
      data_q <= 8'h00;
      for (int i = 0; i < NREGS; i++)
        stg_q[i] <= reset_val(4'(i));
    end else begin
      idx_q  <= idx_d;
      data_q <= data_d;
      for (int i = 0; i < NREGS; i++)
        stg_q[i] <= stg_d[i];
    end
  end

  if (IMMEDIATE) begin : g_imm
    assign com       = stg_q;
    assign pending_o = 1'b0;
    logic unused_imm;
    assign unused_imm = rise ^ dwr ^ changed;
  end else begin : g_stage
    logic [7:0] com_q [NREGS];
    logic [7:0] com_d [NREGS];
    logic       pend_q, pend_d;

    // staging is forwarded so a write on the boundary clk commits too
    always_comb begin
      com_d  = com_q;
      pend_d = pend_q;
      if (changed) pend_d = 1'b1;
      if (rise) begin
        com_d  = stg_d;
        pend_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        pend_q <= 1'b0;
        for (int i = 0; i < NREGS; i++)
          com_q[i] <= reset_val(4'(i));
      end else begin
        pend_q <= pend_d;
        for (int i = 0; i < NREGS; i++)
          com_q[i] <= com_d[i];
      end
    end

    assign com       = com_q;
    assign pending_o = pend_q;
    logic unused_stg;
    assign unused_stg = dwr;
  end

  assign data_o          = data_q;
  assign h_total_o       = com[0];
  assign h_displayed_o   = com[1];
  assign h_sync_pos_o    = com[2];
  assign h_sync_width_o  = com[3][3:0];
  assign v_sync_width_o  = com[3][7:4];
  assign v_total_o       = com[4][6:0];
  assign v_adjust_o      = com[5][4:0];
  assign v_displayed_o   = com[6][6:0];
  assign v_sync_pos_o    = com[7][6:0];
  assign scan_line_o     = com[9][4:0];
  assign display_start_o = {com[12][5:0], com[13]};
  assign cursor_o        = {com[14][5:0], com[15]};

  logic unused_bits;
  assign unused_bits = ^{com[4][7], com[5][7:5], com[6][7],
                         com[7][7], com[8], com[9][7:5],
                         com[10], com[11], com[12][7:6]};

endmodule
